// File: rtl/sdr_parameters.sv
// ============================================================================
// Module      : sdr_parameters (package)
// Description : Shared SDRAM widths, timing constants, command codes and the
//               read-engine state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdr_parameters;

    localparam int ADDR_BITS = 12;
    localparam int ROW_BITS  = 12;
    localparam int COL_BITS  = 9;
    localparam int BA_BITS   = 2;
    localparam int DQ_BITS   = 8;
    localparam int CAS_LAT   = 3;
    localparam int T_RCD     = 3;
    localparam int T_RP      = 3;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;

    typedef enum logic [2:0] {
        RD_IDLE = 3'd0,
        RD_REQ  = 3'd1,
        RD_ACT  = 3'd2,
        RD_READ = 3'd3,
        RD_PRE  = 3'd4
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/sdram_rd_capture.sv
// ============================================================================
// Module      : sdram_rd_capture
// Description : Turns a burst-start pulse into four rFIFO writes of DQ data
//               sampled CAS_LAT cycles after each beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_rd_capture
    import sdr_parameters::*;
(
    input  logic               sdram_clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [DQ_BITS-1:0] i_dq,
    output logic               o_wr_en,
    output logic [DQ_BITS-1:0] o_wr_data,
    output logic               o_pipe_empty
);

    logic [1:0]         r_beat_cnt;
    logic [CAS_LAT-1:0] r_vld;
    logic               r_wr_en;
    logic [DQ_BITS-1:0] r_wr_data;
    logic               w_beat;

    // A beat is live on the start cycle and the three cycles after it.
    assign w_beat = i_start | (r_beat_cnt != 2'd0);

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            r_beat_cnt <= 2'd0;
            r_vld      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
        end else begin
            if (i_start)
                r_beat_cnt <= 2'd3;
            else if (r_beat_cnt != 2'd0)
                r_beat_cnt <= r_beat_cnt - 2'd1;
            r_vld   <= {r_vld[CAS_LAT-2:0], w_beat};
            r_wr_en <= r_vld[CAS_LAT-1];
            if (r_vld[CAS_LAT-1])
                r_wr_data <= i_dq;
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_data    = r_wr_data;
    assign o_pipe_empty = (r_beat_cnt == 2'd0) && (r_vld == '0) && !r_wr_en;

endmodule

`default_nettype wire

// File: rtl/sdram_read.sv
// ============================================================================
// Module      : sdram_read
// Description : SDRAM read engine: ACT / back-to-back READ bursts / PRE per
//               row, yielding to auto-refresh at burst boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_read
    import sdr_parameters::*;
#(
    parameter int COL_ADDR_MAX = 7,
    parameter int ROW_MAX      = 1
) (
    input  logic                 sdram_clk,
    input  logic                 rst,
    input  logic                 rd_trig,
    input  logic                 aref_req,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [DQ_BITS-1:0]   sdram_dq_in,
    output logic                 rd_req,
    output logic [3:0]           rd_cmd,
    output logic [ADDR_BITS-1:0] addr_out,
    output logic [BA_BITS-1:0]   ba_out,
    output logic                 go_aref,
    output logic                 rd_done_all,
    output logic                 rfifo_wr_en,
    output logic [7:0]           rfifo_wr_data
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0]    c_t_rcd       = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0]    c_t_rp        = CNT_W'(T_RP);
    localparam logic [COL_BITS-3:0] c_row_bursts  = (COL_BITS-2)'((COL_ADDR_MAX + 1) / 4);
    localparam logic [ROW_BITS-1:0] c_row_max     = ROW_BITS'(ROW_MAX);

    rd_state_t           r_state, w_next_state;
    logic [ROW_BITS-1:0] r_addr_row;
    logic [ROW_BITS-1:0] r_row_cnt;
    logic [COL_BITS-3:0] r_col_cnt;
    logic [CNT_W-1:0]    r_act_cnt;
    logic [CNT_W-1:0]    r_break_cnt;
    logic [1:0]          r_burst_cnt;
    logic                r_drain;
    logic                r_burst_issued;
    logic                r_aref_t;

    logic w_row_end, w_allow, w_boundary, w_start, w_stop;
    logic w_brk_done, w_done, w_go, w_pipe_empty;

    assign w_row_end  = (r_col_cnt == c_row_bursts);
    assign w_allow    = !w_row_end && !(r_aref_t && r_burst_issued);
    assign w_boundary = (r_state == RD_READ) && !r_drain && (r_burst_cnt == 2'd0);
    assign w_start    = w_boundary && w_allow;
    assign w_stop     = w_boundary && !w_allow;
    assign w_brk_done = (r_state == RD_PRE) && (r_break_cnt == c_t_rp);
    assign w_done     = w_brk_done && w_row_end && (r_row_cnt == c_row_max);
    assign w_go       = w_brk_done && !w_done && r_aref_t;

    always_comb begin
        w_next_state = r_state;
        rd_cmd       = CMD_NOP;
        addr_out     = '0;
        case (r_state)
            RD_IDLE: if (rd_trig) w_next_state = RD_REQ;
            RD_REQ:  if (rd_en)   w_next_state = RD_ACT;
            RD_ACT: begin
                if (r_act_cnt == '0) rd_cmd = CMD_ACT;
                addr_out = ADDR_BITS'(r_addr_row + r_row_cnt);
                if (r_act_cnt == c_t_rcd) w_next_state = RD_READ;
            end
            RD_READ: begin
                if (w_start) rd_cmd = CMD_READ;
                addr_out = ADDR_BITS'({r_col_cnt, 2'b00});
                // Stay in drain until the last captured byte has left.
                if ((r_drain || w_stop) && w_pipe_empty) w_next_state = RD_PRE;
            end
            RD_PRE: begin
                if (r_break_cnt == '0) rd_cmd = CMD_PRE;
                addr_out = ADDR_BITS'(12'h400);
                if (w_brk_done)
                    w_next_state = w_done ? RD_IDLE : (r_aref_t ? RD_REQ : RD_ACT);
            end
            default: w_next_state = RD_IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            r_state        <= RD_IDLE;
            r_addr_row     <= '0;
            r_row_cnt      <= '0;
            r_col_cnt      <= '0;
            r_act_cnt      <= '0;
            r_break_cnt    <= '0;
            r_burst_cnt    <= 2'd0;
            r_drain        <= 1'b0;
            r_burst_issued <= 1'b0;
            r_aref_t       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_go)     r_aref_t <= 1'b0;
            if (aref_req) r_aref_t <= 1'b1;
            case (r_state)
                RD_IDLE: if (rd_trig) begin
                    r_addr_row <= ROW_BITS'(rd_addr);
                    r_row_cnt  <= '0;
                    r_col_cnt  <= '0;
                end
                RD_ACT: begin
                    r_act_cnt      <= (r_act_cnt == c_t_rcd) ? '0 : r_act_cnt + 1'b1;
                    r_burst_issued <= 1'b0;
                    r_burst_cnt    <= 2'd0;
                    r_drain        <= 1'b0;
                end
                RD_READ: begin
                    if (!r_drain && !w_stop) r_burst_cnt <= r_burst_cnt + 2'd1;
                    if (!r_drain && r_burst_cnt == 2'd3) r_col_cnt <= r_col_cnt + 1'b1;
                    if (w_start) r_burst_issued <= 1'b1;
                    if (w_stop)  r_drain <= 1'b1;
                end
                RD_PRE: begin
                    r_break_cnt <= w_brk_done ? '0 : r_break_cnt + 1'b1;
                    // A finished row advances even when the refresh hand-off wins.
                    if (w_brk_done && !w_done && w_row_end) begin
                        r_row_cnt <= r_row_cnt + 1'b1;
                        r_col_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    sdram_rd_capture u_capture (
        .sdram_clk    (sdram_clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_dq         (sdram_dq_in),
        .o_wr_en      (rfifo_wr_en),
        .o_wr_data    (rfifo_wr_data),
        .o_pipe_empty (w_pipe_empty)
    );

    assign rd_req      = (r_state == RD_REQ);
    assign ba_out      = '0;
    assign go_aref     = w_go;
    assign rd_done_all = w_done;

endmodule

`default_nettype wire

// File: tb/tb_sdram_read.sv
// ============================================================================
// Module      : tb_sdram_read
// Description : Scenario table plus randomized runs of the SDRAM read engine
//               against a command-sequence reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_read;
    import sdr_parameters::*;

    localparam int COL_ADDR_MAX = 7;
    localparam int ROW_MAX      = 1;
    localparam int BPR          = (COL_ADDR_MAX + 1) / 4;
    localparam int NBYTES       = (ROW_MAX + 1) * (COL_ADDR_MAX + 1);

    logic        sdram_clk = 1'b0;
    logic        rst = 1'b1, rd_trig = 1'b0, aref_req = 1'b0, rd_en = 1'b0;
    logic [11:0] rd_addr = '0;
    logic [7:0]  sdram_dq_in = '0;
    logic        rd_req, go_aref, rd_done_all, rfifo_wr_en;
    logic [3:0]  rd_cmd;
    logic [11:0] addr_out;
    logic [1:0]  ba_out;
    logic [7:0]  rfifo_wr_data;

    sdram_read #(.COL_ADDR_MAX(COL_ADDR_MAX), .ROW_MAX(ROW_MAX)) dut (
        .sdram_clk(sdram_clk), .rst(rst), .rd_trig(rd_trig), .aref_req(aref_req),
        .rd_en(rd_en), .rd_addr(rd_addr), .sdram_dq_in(sdram_dq_in), .rd_req(rd_req),
        .rd_cmd(rd_cmd), .addr_out(addr_out), .ba_out(ba_out), .go_aref(go_aref),
        .rd_done_all(rd_done_all), .rfifo_wr_en(rfifo_wr_en), .rfifo_wr_data(rfifo_wr_data)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct { int cyc; logic [3:0] cmd; logic [11:0] addr; } cmd_t;
    typedef struct { int cyc; logic [7:0] data; } wr_t;
    typedef struct {
        int id; logic [11:0] addr; int en_dly; int aref_idx; int aref_dly;
        int trig_idx; int exp_go; int exp_acts;
    } vec_t;

    cmd_t cmd_q[$], exp_q[$];
    wr_t  wr_q[$];
    int   go_q[$], done_q[$], rcyc[$];
    int   dq_sched[int];
    int   cyc = 0, n_tests = 0, n_fail = 0, model_go = 0, model_acts = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One cycle: sample outputs mid-cycle, log events, drive the DQ model.
    task automatic step();
        @(negedge sdram_clk);
        cyc++;
        if (rd_cmd != CMD_NOP) cmd_q.push_back('{cyc, rd_cmd, addr_out});
        if (rd_cmd == CMD_READ) begin
            rcyc.push_back(cyc);
            for (int k = 0; k < 4; k++) dq_sched[cyc + CAS_LAT + k] = 16 + int'(addr_out) + k;
        end
        if (rfifo_wr_en) wr_q.push_back('{cyc, rfifo_wr_data});
        if (go_aref)     go_q.push_back(cyc);
        if (rd_done_all) done_q.push_back(cyc);
        sdram_dq_in = dq_sched.exists(cyc) ? 8'(dq_sched[cyc]) : 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_trig = 1'b0; aref_req = 1'b0; rd_en = 1'b0;
        step(); step();
        rst = 1'b0;
        cmd_q.delete(); wr_q.delete(); go_q.delete(); done_q.delete(); rcyc.delete();
        dq_sched.delete();
    endtask

    // Expected command stream: every row gets ACT, its bursts in column order
    // and a PRE; a refresh latched before the next burst boundary of the same
    // row splits the row with an extra PRE/ACT pair.
    function automatic void build_model(input vec_t v);
        int split = -1;
        logic [11:0] ra;
        exp_q.delete();
        if (v.aref_idx >= 0 && v.aref_dly <= 3 && (v.aref_idx % BPR) != BPR - 1)
            split = v.aref_idx + 1;
        model_go = (v.aref_idx >= 0 && (split >= 0 || v.aref_idx / BPR < ROW_MAX)) ? 1 : 0;
        model_acts = 0;
        for (int g = 0; g < BPR * (ROW_MAX + 1); g++) begin
            ra = v.addr + 12'(g / BPR);
            if (g % BPR == 0 || g == split) begin
                if (g == split) exp_q.push_back('{0, CMD_PRE, 12'h400});
                exp_q.push_back('{0, CMD_ACT, ra});
                model_acts++;
            end
            exp_q.push_back('{0, CMD_READ, 12'((g % BPR) * 4)});
            if (g % BPR == BPR - 1) exp_q.push_back('{0, CMD_PRE, 12'h400});
        end
    endfunction

    task automatic run_scenario(input vec_t v);
        int  req_age = 0, acts = 0;
        bit  fin = 0;
        string s;
        s = $sformatf("s%0d", v.id);
        do_reset();
        build_model(v);
        rd_addr = v.addr; rd_trig = 1'b1;
        for (int i = 0; i < 400 && !fin; i++) begin
            step();
            rd_trig = 1'b0;
            if (rd_req) begin req_age++; rd_en = (req_age > v.en_dly); end
            else begin req_age = 0; rd_en = 1'b0; end
            aref_req = (v.aref_idx >= 0 && rcyc.size() > v.aref_idx &&
                        cyc == rcyc[v.aref_idx] + v.aref_dly);
            rd_trig  = (v.trig_idx >= 0 && rcyc.size() > v.trig_idx &&
                        cyc == rcyc[v.trig_idx] + 2);
            rd_addr  = rd_trig ? ~v.addr : v.addr;
            if (rd_done_all) fin = 1;
        end
        rd_trig = 1'b0; aref_req = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 12; i++) step();
        if (!fin) chk({s, ".timeout"}, 0, 1);
        foreach (cmd_q[j]) if (cmd_q[j].cmd == CMD_ACT) acts++;
        chk({s, ".done_cnt"}, done_q.size(), 1);
        chk({s, ".go_cnt"}, go_q.size(), v.exp_go);
        chk({s, ".act_cnt"}, acts, v.exp_acts);
        chk({s, ".bytes"}, wr_q.size(), NBYTES);
        chk({s, ".cmd_len"}, cmd_q.size(), exp_q.size());
        for (int j = 0; j < cmd_q.size() && j < exp_q.size(); j++)
            chk($sformatf("%s.cmd%0d", s, j), {cmd_q[j].cmd, cmd_q[j].addr},
                {exp_q[j].cmd, exp_q[j].addr});
        for (int j = 0; j < wr_q.size() && j < NBYTES; j++)
            chk($sformatf("%s.data%0d", s, j), wr_q[j].data, 16 + (j % (COL_ADDR_MAX + 1)));
        for (int j = 0; j < rcyc.size(); j++)
            for (int m = 0; m < 4 && 4 * j + m < wr_q.size(); m++)
                chk($sformatf("%s.strobe%0d_%0d", s, j, m), wr_q[4*j+m].cyc,
                    rcyc[j] + CAS_LAT + 1 + m);
        for (int j = 1; j < cmd_q.size(); j++) begin
            if (cmd_q[j].cmd == CMD_READ && cmd_q[j-1].cmd == CMD_ACT)
                chk($sformatf("%s.trcd%0d", s, j), cmd_q[j].cyc - cmd_q[j-1].cyc, T_RCD + 1);
            if (cmd_q[j].cmd == CMD_READ && cmd_q[j-1].cmd == CMD_READ)
                chk($sformatf("%s.b2b%0d", s, j), cmd_q[j].cyc - cmd_q[j-1].cyc, 4);
            if (cmd_q[j].cmd == CMD_ACT && cmd_q[j-1].cmd == CMD_PRE &&
                !(cmd_q[j-1].cyc + T_RP inside {go_q}))
                chk($sformatf("%s.trp%0d", s, j), cmd_q[j].cyc - cmd_q[j-1].cyc, T_RP + 1);
        end
        foreach (go_q[j]) begin
            int hit = 0;
            foreach (cmd_q[k]) if (cmd_q[k].cmd == CMD_PRE && cmd_q[k].cyc + T_RP == go_q[j]) hit = 1;
            chk($sformatf("%s.go_after_pre%0d", s, j), hit, 1);
        end
        if (done_q.size() > 0 && cmd_q.size() > 0)
            chk({s, ".done_time"}, done_q[0], cmd_q[$].cyc + T_RP);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t rv;
        int   guard;
        int   bad;

        // Reset state.
        do_reset();
        chk("rst.cmd", rd_cmd, CMD_NOP);
        chk("rst.addr", addr_out, 0);
        chk("rst.ba", ba_out, 0);
        chk("rst.flags", {rd_req, go_aref, rd_done_all, rfifo_wr_en}, 0);
        chk("rst.wdata", rfifo_wr_data, 0);

        // Reset in the middle of a burst discards the read in flight.
        rd_addr = 12'd5; rd_trig = 1'b1;
        guard = 0;
        while (rcyc.size() == 0 && guard < 100) begin
            step(); rd_trig = 1'b0; rd_en = rd_req; guard++;
        end
        chk("midrst.read_seen", rcyc.size(), 1);
        step();
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk("midrst.cmd", rd_cmd, CMD_NOP);
        chk("midrst.idle", {rd_req, addr_out}, 0);
        chk("midrst.wdata", rfifo_wr_data, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rfifo_wr_en || rd_cmd != CMD_NOP) bad++;
        end
        chk("midrst.quiet", bad, 0);

        //          id addr     en aidx adly trig go acts
        tbl[0] = '{1, 12'd5,    1, -1,  0,   -1,  0, 2};   // basic
        tbl[1] = '{2, 12'd5,    1,  0,  1,   -1,  1, 3};   // refresh mid-row
        tbl[2] = '{3, 12'd5,    1,  1,  1,   -1,  1, 2};   // refresh with row end
        tbl[3] = '{4, 12'd5,    1, -1,  0,    0,  0, 2};   // trigger while busy
        tbl[4] = '{5, 12'hFFF,  0, -1,  0,   -1,  0, 2};   // row address wrap
        tbl[5] = '{6, 12'h2A0,  3,  2,  5,   -1,  0, 2};   // refresh too late to hand off
        for (int i = 0; i < 6; i++) run_scenario(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            rv.id       = 100 + i;
            rv.addr     = 12'($urandom);
            rv.en_dly   = $urandom_range(0, 4);
            rv.aref_idx = int'($urandom_range(0, 4)) - 1;
            rv.aref_dly = $urandom_range(0, 6);
            rv.trig_idx = int'($urandom_range(0, 2)) - 1;
            build_model(rv);
            rv.exp_go   = model_go;
            rv.exp_acts = model_acts;
            run_scenario(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sdram_read.md
Name: sdram_read

Overview:
SDRAM READ engine, no auto-precharge, in the sdram_clk domain. It is the read-side counterpart of the write engine.
- On a read trigger it requests the arbiter, then issues ACT / READ bursts / PRE.
- It captures DQ after CAS latency and pushes bytes into the rFIFO for the UART TX path.
- It yields to AUTO-REFRESH at a burst boundary and resumes at the saved row/column.

Parameters:
ADDR_BITS, 12, SDRAM address width A11..A0
ROW_BITS, 12, row address width
COL_BITS, 9, column address width
BA_BITS, 2, bank address width
DQ_BITS, 8, data width (rFIFO byte)
CAS_LAT, 3, CAS latency in cycles
T_RCD, 3, ACT-to-READ cycles
T_RP, 3, PRE-to-next-command cycles
COL_ADDR_MAX, 7, last column read per row (two bursts of 4)
ROW_MAX, 1, number of consecutive rows minus 1

Ports:
sdram_clk  in  1  SDRAM clock; the only clock
rst  in  1  reset
rd_trig  in  1  start a full read sequence (pulse)
aref_req  in  1  refresh request from the refresh block
rd_en  in  1  arbiter grant
rd_addr  in  ADDR_BITS  start row
sdram_dq_in  in  DQ_BITS  SDRAM read data
rd_req  out  1  request to arbiter
rd_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}
addr_out  out  ADDR_BITS  SDRAM A11..A0
ba_out  out  BA_BITS  bank, constant 0
go_aref  out  1  one-cycle pulse: banks precharged, handing over to refresh
rd_done_all  out  1  one-cycle pulse: whole sequence finished
rfifo_wr_en  out  1  rFIFO write strobe
rfifo_wr_data  out  8  rFIFO write data

Behaviour:
- Clock and reset: one clock, sdram_clk. Reset rst is synchronous and active-high.
- Reset (also mid-operation) forces:
  - state RD_IDLE, all counters 0, aref_req_t 0, capture pipeline cleared;
  - rd_cmd=NOP (0111), addr_out=0, ba_out=0;
  - rd_req, go_aref, rd_done_all, rfifo_wr_en = 0, rfifo_wr_data=0;
  - in-flight read data is discarded.
- Command codes: NOP 0111, ACT 0011, READ 0101, PRE 0010.
- RD_IDLE:
  - rd_trig=1 latches addr_row<=rd_addr, clears row_cnt and col_cnt, then goes to RD_REQ.
  - rd_trig is ignored in every other state.
- RD_REQ: rd_req=1 (combinational on state). rd_en=1 -> RD_ACT.
- RD_ACT:
  - act_cnt counts up from 0; rd_cmd=ACT only when act_cnt==0.
  - addr_out = addr_row+row_cnt, truncated to ROW_BITS.
  - act_cnt==T_RCD -> RD_READ.
- RD_READ:
  - burst_cnt runs 0..3. rd_cmd=READ when burst_cnt==0 and another burst is allowed.
  - addr_out = {zero pad, col_cnt, 2'b00}, A10=0. col_cnt increments when burst_cnt==3.
  - Bursts are issued back-to-back, one READ every 4 cycles.
  - A burst is not issued, and the engine enters drain, when either:
    - the previous burst ended at column COL_ADDR_MAX, or
    - aref_req_t=1 and at least one burst has been issued since ACT.
  - Drain: NOP until the capture pipeline is empty, then RD_PRE.
- Capture: for a READ in cycle t, rfifo_wr_en=1 in cycles t+CAS_LAT+1 .. t+CAS_LAT+4. rfifo_wr_data is sdram_dq_in registered at cycle t+CAS_LAT+k.
- RD_PRE:
  - break_cnt counts; rd_cmd=PRE only when break_cnt==0; addr_out=12'h400 (A10=1, all banks).
  - When break_cnt==T_RP, exactly one of the following applies, in this priority:
    - Last row and last column read: rd_done_all pulses -> RD_IDLE.
    - aref_req_t=1: go_aref pulses, aref_req_t clears -> RD_REQ. The saved row_cnt/col_cnt are kept, so the sequence resumes where it stopped.
    - Row finished: row_cnt+1, col_cnt=0 -> RD_ACT.
- aref_req_t: set by aref_req, held until go_aref. An aref_req arriving during RD_ACT still allows one burst.
- Simultaneous events: if the row end and aref_req_t coincide, the row end takes effect first (row_cnt advances, col_cnt=0) and the refresh hand-off happens at the same PRE.
- Total bytes delivered: (ROW_MAX+1)*(COL_ADDR_MAX+1).

Decomposition:
- Shared package sdr_parameters: ADDR_BITS, ROW_BITS, COL_BITS, BA_BITS, DQ_BITS, the CMD_* codes, T_RCD, T_RP, CAS_LAT.
- Sub-module sdram_rd_capture: a CAS_LAT+1 deep valid shift register plus the data register. Inputs: burst-start pulse and sdram_dq_in. Outputs: rfifo_wr_en, rfifo_wr_data, pipe_empty.

Test Plan:
- Reset: assert rst for 2 cycles while in RD_READ -> next cycle RD_IDLE, rd_cmd=0111, no rfifo_wr_en afterwards.
- Basic: rd_trig with rd_addr=5, rd_en one cycle after rd_req -> ACT with addr 5, READ col 0 after 3 cycles, READ col 4 four cycles later. Then PRE addr 0x400, ACT addr 6, same two READs, final PRE and rd_done_all pulse.
- Data: DQ model returns 0x10+column -> rFIFO receives 0x10..0x17 twice (16 writes), first strobe 4 cycles after first READ.
- Refresh: pulse aref_req during first burst of row 0 -> no second READ, PRE, go_aref pulse, RD_REQ. After rd_en, ACT row 5 and READ col 4.
- Coincident events: aref_req during last burst of row 0 -> single PRE, go_aref, resume with ACT row 6 col 0.
- Trigger while busy: rd_trig while in RD_READ -> ignored, sequence unchanged, exactly one rd_done_all.
